mem_port_arbiter: RTL and testbench

Shares the core's single external memory port between instruction fetch and data load/store. Two requesters present held-until-acknowledged requests. The block arbitrates between them, drives one transaction at a time to memory, and routes the acknowledge and read data back to the winner. It adds a starvation guard for fetch and a no-acknowledge timeout, so a bad address cannot hang the pipeline.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_port_arbiter_arb_priority_sel.sv | 23 ++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and the
// requester-select code produced by the grant selector.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_IF   = 2'd1,
    SEL_D    = 2'd2
  } arb_sel_e;

endpackage

// File: rtl/mem_port_arbiter_arb_priority_sel.sv
// Combinational grant selection: data has priority unless fetch has been
// starved for the configured number of consecutive data grants.
module arb_priority_sel
  import mem_arb_pkg::*;
(
  input  logic     if_req_i,
  input  logic     d_req_i,
  input  logic     starve_hit_i,
  output arb_sel_e sel_o
);

  always_comb begin
    sel_o = SEL_NONE;
    if (if_req_i && d_req_i) begin
      sel_o = starve_hit_i ? SEL_IF : SEL_D;
    end else if (if_req_i) begin
      sel_o = SEL_IF;
    end else if (d_req_i) begin
      sel_o = SEL_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and data
// load/store, with a fetch starvation guard and a no-acknowledge timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH_P   = 32,
  parameter int ADDR_WIDTH_P   = 32,
  parameter int STARVE_LIMIT_P = 4,
  parameter int TIMEOUT_P      = 64,
  parameter int CNT_WIDTH_P    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_if_req,
  input  logic [ADDR_WIDTH_P-1:0] i_if_addr,
  output logic                    o_if_ack,
  output logic [DATA_WIDTH_P-1:0] o_if_rdata,
  input  logic                    i_d_req,
  input  logic                    i_d_we,
  input  logic [ADDR_WIDTH_P-1:0] i_d_addr,
  input  logic [DATA_WIDTH_P-1:0] i_d_wdata,
  output logic                    o_d_ack,
  output logic [DATA_WIDTH_P-1:0] o_d_rdata,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH_P-1:0] o_mem_addr,
  output logic [DATA_WIDTH_P-1:0] o_mem_wdata,
  input  logic                    i_mem_ack,
  input  logic [DATA_WIDTH_P-1:0] i_mem_rdata,
  output logic                    o_timeout,
  output logic                    o_busy
);

  localparam logic [CNT_WIDTH_P-1:0] STARVE_LIM = CNT_WIDTH_P'(STARVE_LIMIT_P);
  localparam logic [CNT_WIDTH_P-1:0] TMO_LIM    = CNT_WIDTH_P'(TIMEOUT_P);
  localparam logic [CNT_WIDTH_P-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH_P-1:0] CNT_ONE    = CNT_WIDTH_P'(1);

  function automatic logic [CNT_WIDTH_P-1:0] sat_inc(
    input logic [CNT_WIDTH_P-1:0] v,
    input logic [CNT_WIDTH_P-1:0] lim
  );
    return (v >= lim) ? lim : v + CNT_ONE;
  endfunction

  arb_state_e             state_q, state_d;
  arb_sel_e               sel;
  logic [CNT_WIDTH_P-1:0] starve_q, starve_d;
  logic [CNT_WIDTH_P-1:0] tmo_q, tmo_d;
  logic                   busy, starve_hit, tmo_fire, done, grant;

  assign busy       = (state_q != ST_IDLE);
  assign starve_hit = (starve_q == STARVE_LIM);
  // Ack wins over a coincident timeout.
  assign tmo_fire   = (TIMEOUT_P != 0) && busy && (tmo_q == TMO_LIM) && !i_mem_ack;
  assign done       = busy && (i_mem_ack || tmo_fire);
  assign grant      = (state_q == ST_IDLE) && (sel != SEL_NONE);

  arb_priority_sel u_sel (
    .if_req_i     (i_if_req),
    .d_req_i      (i_d_req),
    .starve_hit_i (starve_hit),
    .sel_o        (sel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sel == SEL_IF) begin
          state_d = ST_BUSY_I;
        end else if (sel == SEL_D) begin
          state_d = ST_BUSY_D;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_if_ack   = (state_q == ST_BUSY_I) && done;
    o_d_ack    = (state_q == ST_BUSY_D) && done;
    o_if_rdata = ((state_q == ST_BUSY_I) && i_mem_ack) ? i_mem_rdata : '0;
    o_d_rdata  = ((state_q == ST_BUSY_D) && i_mem_ack) ? i_mem_rdata : '0;
    o_timeout  = tmo_fire;
    o_busy     = busy;
  end

  // Starve count only moves while idle; it tracks data grants made over a waiting fetch.
  always_comb begin
    starve_d = starve_q;
    tmo_d    = tmo_q;
    if (state_q == ST_IDLE) begin
      tmo_d = grant ? CNT_ONE : '0;
      if ((sel == SEL_IF) || !i_if_req) begin
        starve_d = '0;
      end else if (sel == SEL_D) begin
        starve_d = sat_inc(starve_q, STARVE_LIM);
      end
    end else begin
      tmo_d = sat_inc(tmo_q, CNT_MAX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q    <= '0;
      tmo_q       <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
      if (grant) begin
        o_mem_req   <= 1'b1;
        o_mem_we    <= (sel == SEL_D) && i_d_we;
        o_mem_addr  <= (sel == SEL_D) ? i_d_addr : i_if_addr;
        o_mem_wdata <= (sel == SEL_D) ? i_d_wdata : '0;
      end else if (done) begin
        o_mem_req <= 1'b0;
        o_mem_we  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants and completions are
// queued when requests are driven and compared as the DUT produces them.
module tb_mem_port_arbiter;

  localparam logic [31:0] BAD_ADDR = 32'h0000_BAD0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic        if_ack, d_ack, mem_req, mem_we, mem_ack, tmo, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(
    .DATA_WIDTH_P(32), .ADDR_WIDTH_P(32), .STARVE_LIMIT_P(4),
    .TIMEOUT_P(8), .CNT_WIDTH_P(8)
  ) dut (
    .clk(clk), .reset(reset),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_ack(d_ack), .o_d_rdata(d_rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_timeout(tmo), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Memory model: acks mem_lat cycles after the request rises, never for BAD_ADDR.
  int          busy_cyc = 0;
  int          mem_lat = 0;
  logic [31:0] mem_data = '0;
  bit          force_ack = 1'b0;
  int          cyc_n = 0;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    #1;
    busy_cyc = mem_req ? busy_cyc + 1 : 0;
  end

  assign mem_ack   = force_ack | (mem_req && (mem_addr != BAD_ADDR) && (busy_cyc == mem_lat + 1));
  assign mem_rdata = mem_data;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } grant_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          tmo;
    int          cyc;
  } cmpl_t;

  grant_t gq[$];
  cmpl_t  cq[$];
  logic   prev_req = 1'b0;
  bit     chk_spacing = 1'b0;
  int     last_grant = -1;

  always @(negedge clk) begin
    if (mem_req && !prev_req) begin
      check_eq("grant_expected", gq.size() > 0, 1);
      if (gq.size() > 0) begin
        grant_t g;
        g = gq.pop_front();
        check_eq("grant_addr", mem_addr, g.addr);
        check_eq("grant_we", mem_we, g.we);
        if (g.we) check_eq("grant_wdata", mem_wdata, g.wdata);
      end
      if (chk_spacing && last_grant >= 0) check_eq("grant_spacing", cyc_n - last_grant, 2);
      last_grant = cyc_n;
    end
    prev_req = mem_req;
    if (if_ack || d_ack) begin
      check_eq("single_ack", if_ack & d_ack, 0);
      check_eq("ack_expected", cq.size() > 0, 1);
      if (cq.size() > 0) begin
        cmpl_t c;
        c = cq.pop_front();
        check_eq("ack_who", d_ack, c.is_d);
        check_eq("ack_rdata", c.is_d ? d_rdata : if_rdata, c.rdata);
        check_eq("other_rdata", c.is_d ? if_rdata : d_rdata, 0);
        check_eq("ack_timeout", tmo, c.tmo);
        if (c.cyc > 0) check_eq("ack_cycle", busy_cyc, c.cyc);
      end
    end
  end

  task automatic exp_grant(input logic [31:0] a, input logic we, input logic [31:0] wd);
    grant_t g;
    g.addr = a; g.we = we; g.wdata = wd;
    gq.push_back(g);
  endtask

  task automatic exp_cmpl(input bit is_d, input logic [31:0] rd, input bit t, input int cyc);
    cmpl_t c;
    c.is_d = is_d; c.rdata = rd; c.tmo = t; c.cyc = cyc;
    cq.push_back(c);
  endtask

  // Holds a request until n acks have been seen, then drops it in the following cycle.
  task automatic req_drive(input bit is_d, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input int n);
    int acks = 0;
    int waited = 0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    while (acks < n && waited < 200) begin
      @(negedge clk);
      waited++;
      if (is_d ? d_ack : if_ack) acks++;
    end
    @(posedge clk); #1;
    if (is_d) begin
      d_req = 1'b0;
      check_eq("d_ack_count", acks, n);
    end else begin
      if_req = 1'b0;
      check_eq("if_ack_count", acks, n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    #2;
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_timeout", tmo, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single fetch, 3-cycle memory latency
    mem_lat = 3; mem_data = 32'hDEAD_BEEF;
    exp_grant(32'h100, 1'b0, '0);
    exp_cmpl(1'b0, 32'hDEAD_BEEF, 1'b0, 4);
    fork
      req_drive(1'b0, 1'b0, 32'h100, '0, 1);
      begin
        @(negedge clk); check_eq("fetch_req_c0", mem_req, 0);
        @(negedge clk); check_eq("fetch_req_c1", mem_req, 1);
        check_eq("fetch_we", mem_we, 0);
      end
    join
    repeat (2) @(posedge clk); #1;

    // Store, zero-latency memory
    mem_lat = 0; mem_data = 32'h0;
    exp_grant(32'h200, 1'b1, 32'h1234_5678);
    exp_cmpl(1'b1, 32'h0, 1'b0, 1);
    req_drive(1'b1, 1'b1, 32'h200, 32'h1234_5678, 1);
    @(negedge clk);
    check_eq("store_we_cleared", mem_we, 0);
    check_eq("store_idle", busy, 0);
    @(posedge clk); #1;

    // Contention: grant order D,D,D,D,I,D,D,D,D,I
    mem_data = 32'h0BAD_F00D;
    for (int k = 0; k < 10; k++) begin
      bit f;
      f = (k == 4) || (k == 9);
      exp_grant(f ? 32'h300 : 32'h400, 1'b0, '0);
      exp_cmpl(!f, 32'h0BAD_F00D, 1'b0, 1);
    end
    chk_spacing = 1'b1; last_grant = -1;
    fork
      req_drive(1'b1, 1'b0, 32'h400, '0, 8);
      req_drive(1'b0, 1'b0, 32'h300, '0, 2);
    join
    chk_spacing = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Timeout on a fetch to a dead address, then a pending load is served
    mem_lat = 1; mem_data = 32'h1111_1111;
    exp_grant(BAD_ADDR, 1'b0, '0);
    exp_cmpl(1'b0, 32'h0, 1'b1, 8);
    exp_grant(32'h500, 1'b0, '0);
    exp_cmpl(1'b1, 32'h1111_1111, 1'b0, 2);
    fork
      req_drive(1'b0, 1'b0, BAD_ADDR, '0, 1);
      begin
        repeat (2) @(posedge clk); #1;
        req_drive(1'b1, 1'b0, 32'h500, '0, 1);
      end
    join
    repeat (2) @(posedge clk); #1;

    // Ack arriving in the timeout cycle wins
    mem_lat = 7; mem_data = 32'hA5A5_A5A5;
    exp_grant(32'h700, 1'b0, '0);
    exp_cmpl(1'b1, 32'hA5A5_A5A5, 1'b0, 8);
    req_drive(1'b1, 1'b0, 32'h700, '0, 1);
    repeat (2) @(posedge clk); #1;

    // Memory ack while idle is ignored
    force_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("idle_if_ack", if_ack, 0);
      check_eq("idle_d_ack", d_ack, 0);
      check_eq("idle_busy", busy, 0);
    end
    @(posedge clk); #1 force_ack = 1'b0;

    // Asynchronous reset in the middle of a store
    exp_grant(BAD_ADDR, 1'b1, 32'h0000_0077);
    d_req = 1'b1; d_we = 1'b1; d_addr = BAD_ADDR; d_wdata = 32'h77;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_busy", busy, 1);
    #3 reset = 1'b1;
    #1;
    check_eq("arst_mem_req", mem_req, 0);
    check_eq("arst_mem_we", mem_we, 0);
    check_eq("arst_mem_addr", mem_addr, 0);
    check_eq("arst_mem_wdata", mem_wdata, 0);
    check_eq("arst_busy", busy, 0);
    d_req = 1'b0; d_we = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    mem_lat = 2; mem_data = 32'h600D_600D;
    exp_grant(32'h600, 1'b0, '0);
    exp_cmpl(1'b0, 32'h600D_600D, 1'b0, 3);
    req_drive(1'b0, 1'b0, 32'h600, '0, 1);
    repeat (3) @(posedge clk);

    check_eq("grants_left", gq.size(), 0);
    check_eq("acks_left", cq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
